// File: rtl/mp_pkg.sv
// Shared types and constants for the 8-bit multi-cycle sequencer.
// Opcode and state encodings plus the datapath width.
package mp_pkg;

  localparam int W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_J   = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

endpackage

// File: rtl/mp_decode.sv
// Combinational instruction field decoder.
// Splits IR into opcode, register fields and sign-extended immediates.
module mp_decode
  import mp_pkg::*;
(
  input  logic [W-1:0] ir,
  output op_t          op,
  output logic [1:0]   rs,
  output logic [1:0]   rt,
  output logic [1:0]   rd,
  output logic [W-1:0] imm_ext,
  output logic [W-1:0] jmp_ext
);

  assign op      = op_t'(ir[7:6]);
  assign rs      = ir[5:4];
  assign rt      = ir[3:2];
  assign rd      = ir[1:0];
  assign imm_ext = {{(W-2){ir[1]}}, ir[1:0]};
  assign jmp_ext = {{(W-6){ir[5]}}, ir[5:0]};

endmodule

// File: rtl/mp_control.sv
// Multi-cycle fetch/decode/exec/mem/wb sequencer for the 8-bit CPU.
// Owns PC and IR; talks to both memories over req/ack handshakes.
module mp_control
  import mp_pkg::*;
#(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_data,
  output logic [1:0]   rs_addr,
  output logic [1:0]   rt_addr,
  output logic [1:0]   rd_addr,
  output logic         reg_we,
  output logic         wb_sel,
  output logic         alu_op,
  output logic         alu_b_sel,
  output logic [W-1:0] imm_ext,
  input  logic [W-1:0] alu_result,
  output logic [W-1:0] dmem_addr,
  output logic         dmem_req,
  output logic         dmem_we,
  input  logic         dmem_ack,
  output logic         busy,
  output logic [W-1:0] retired
);

  state_t       state, next;
  logic [W-1:0] pc, ir;
  logic [W-1:0] jmp_ext;
  logic [1:0]   rd;
  op_t          op;
  logic         retire;

  mp_decode u_decode (
    .ir      (ir),
    .op      (op),
    .rs      (rs_addr),
    .rt      (rt_addr),
    .rd      (rd),
    .imm_ext (imm_ext),
    .jmp_ext (jmp_ext)
  );

  assign imem_addr = pc;
  assign busy      = (state != S_IDLE);

  always_comb begin
    next   = state;
    retire = 1'b0;
    unique case (state)
      S_IDLE:   if (run) next = S_FETCH;
      S_FETCH:  if (imem_ack) next = S_DECODE;
      S_DECODE: next = S_EXEC;
      S_EXEC: begin
        unique case (op)
          OP_ADD:       next = S_WB;
          OP_LW, OP_SW: next = S_MEM;
          default:      retire = 1'b1;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (op == OP_LW) next = S_WB;
          else retire = 1'b1;
        end
      end
      S_WB:    retire = 1'b1;
      default: next = S_IDLE;
    endcase
    // run is only honoured at instruction boundaries
    if (retire) next = run ? S_FETCH : S_IDLE;
  end

  always_comb begin
    alu_op    = 1'b0;
    alu_b_sel = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    rd_addr   = '0;
    unique case (1'b1)
      (state == S_EXEC): begin
        alu_op    = (op != OP_J);
        alu_b_sel = (op == OP_LW) || (op == OP_SW);
      end
      (state == S_WB): begin
        reg_we  = 1'b1;
        wb_sel  = (op == OP_LW);
        rd_addr = (op == OP_LW) ? rt_addr : rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= PC_RESET;
      ir        <= '0;
      retired   <= '0;
      dmem_addr <= '0;
      imem_req  <= 1'b0;
      dmem_req  <= 1'b0;
      dmem_we   <= 1'b0;
    end else begin
      state    <= next;
      imem_req <= (next == S_FETCH);
      dmem_req <= (next == S_MEM);
      dmem_we  <= (next == S_MEM) && (op == OP_SW);
      if (state == S_FETCH && imem_ack) begin
        ir <= imem_data;
        pc <= pc + 8'd1;
      end
      if (state == S_EXEC) begin
        dmem_addr <= alu_result;
        if (op == OP_J) pc <= pc + jmp_ext;
      end
      if (retire) retired <= retired + 8'd1;
    end
  end

endmodule
